vreg_bank: RTL

Parametrised vector register bank for the vector datapath, the successor of the scalar 32-bit register bank. Each entry holds LANES elements of WIDTH bits. The bank provides two combinational read ports, one lane-masked write port with same-cycle write-to-read forwarding, and a hardwired-zero option for entry 0. A clear sequencer zeroes every entry after reset or on request, one entry per cycle, and reports BUSY while clearing. Decode and execute read operands here; writeback writes results here.

---
 rtl/vreg_bank.sv | 101 ++++++++++
 1 files changed

// File: rtl/vreg_bank.sv
// Vector register bank: LANES x WIDTH per entry, two combinational read ports,
// one lane-masked write port with forwarding, and a one-entry-per-cycle clear sequencer.
module vreg_bank #(
    parameter int WIDTH    = 32,
    parameter int LANES    = 4,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WE3,
    input  logic [LANES-1:0]         WM3,
    input  logic [ADDR_W-1:0]        RA1,
    input  logic [ADDR_W-1:0]        RA2,
    input  logic [ADDR_W-1:0]        RA3,
    input  logic [LANES*WIDTH-1:0]   WD3,
    input  logic                     CLR,
    output logic [LANES*WIDTH-1:0]   RD1,
    output logic [LANES*WIDTH-1:0]   RD2,
    output logic                     BUSY
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_next;
    logic [WIDTH-1:0]  mem [DEPTH][LANES];

    logic [ADDR_W-1:0] clr_idx;
    logic              write_ok;

    assign clr_idx  = cnt[ADDR_W-1:0];
    assign write_ok = WE3 && !(ZERO_EN && (RA3 == '0));
    assign BUSY     = (state == CLEAR);

    // NOTE: RST is synchronous and wins over CLR and the sequencer itself.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: hold-values are assigned first so no path through this block infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (CLR) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt + 1'b1;
                if (cnt == LAST) state_next = IDLE;
            end
            default: state_next = CLEAR;
        endcase
    end

    // NOTE: storage has no reset branch; its contents are defined only by the clear sequencer.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == CLEAR) begin
                for (int l = 0; l < LANES; l++) mem[clr_idx][l] <= '0;
            end else if (write_ok) begin
                for (int l = 0; l < LANES; l++) begin
                    if (WM3[l]) mem[RA3][l] <= WD3[l*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Per-lane read mux: busy blanking, hardwired zero, forwarding, then storage.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic fwd1;
        logic fwd2;
        assign fwd1 = WE3 && WM3[i] && (RA3 == RA1);
        assign fwd2 = WE3 && WM3[i] && (RA3 == RA2);

        assign RD1[i*WIDTH +: WIDTH] = (BUSY || (ZERO_EN && (RA1 == '0))) ? '0 :
                                       fwd1 ? WD3[i*WIDTH +: WIDTH] : mem[RA1][i];
        assign RD2[i*WIDTH +: WIDTH] = (BUSY || (ZERO_EN && (RA2 == '0))) ? '0 :
                                       fwd2 ? WD3[i*WIDTH +: WIDTH] : mem[RA2][i];
    end

endmodule
